// File: rtl/csi_rx_packet_decoder.sv
// CSI-2 receive-side packet decoder: parses FS/FE short packets and RAW14 long
// packets, checks ECC/VC/WC/CRC-16, unpacks pixels four at a time, counts lines.
module csi_rx_packet_decoder #(
  parameter logic [1:0] EXP_VC            = 2'h0,
  parameter logic [7:0] EXP_ECC           = 8'hCC,
  parameter logic [5:0] DT_RAW14          = 6'h2D,
  parameter logic [5:0] DT_FS             = 6'h00,
  parameter logic [5:0] DT_FE             = 6'h01,
  parameter int         IMAGE_LINES       = 4,
  parameter int         IMAGE_LINE_PIXELS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic        rx_eop,
  output logic        fs_pulse,
  output logic        fe_pulse,
  output logic [15:0] frame_num,
  output logic        quad_valid,
  output logic [55:0] quad_pix,
  output logic        line_start,
  output logic        line_end,
  output logic [15:0] line_cnt,
  output logic        err_ecc,
  output logic        err_vc,
  output logic        err_dt,
  output logic        err_wc,
  output logic        err_len,
  output logic        err_crc,
  output logic        err_frame
);

  localparam logic [15:0] LINE_BYTES  = 16'(IMAGE_LINE_PIXELS * 14 / 8);
  localparam logic [15:0] FRAME_LINES = 16'(IMAGE_LINES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PAYLOAD,
    S_CRC,
    S_DISCARD
  } state_t;

  state_t      state;
  logic [1:0]  hdr_cnt;
  logic [7:0]  hdr_di;
  logic [7:0]  hdr_lsb;
  logic [7:0]  hdr_msb;
  logic [15:0] byte_cnt;
  logic [2:0]  grp_cnt;
  logic [7:0]  grp_buf [0:5];
  logic [15:0] crc;
  logic [7:0]  crc_lo;
  logic        crc_idx;

  logic [1:0]  hdr_vc;
  logic [5:0]  hdr_dt;
  logic [15:0] hdr_wc;
  logic        wc_ok;
  logic [55:0] quad_next;

  // Reflected CRC-16 (x^16+x^12+x^5+1), one data bit per step, LSB first.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'h8408;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // NOTE: every signal here is assigned on every pass, so no latch can be
  // inferred; any future conditional logic needs a default assignment first.
  always_comb begin
    hdr_vc    = hdr_di[7:6];
    hdr_dt    = hdr_di[5:0];
    hdr_wc    = {hdr_msb, hdr_lsb};
    wc_ok     = (hdr_wc != 16'd0) && ((hdr_wc % 16'd7) == 16'd0) && (hdr_wc == LINE_BYTES);
    // Current byte is b6; b0..b5 sit in grp_buf.
    quad_next = {grp_buf[3], rx_byte[7:2],
                 grp_buf[2], rx_byte[1:0], grp_buf[5][7:4],
                 grp_buf[1], grp_buf[5][3:0], grp_buf[4][7:6],
                 grp_buf[0], grp_buf[4][5:0]};
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      hdr_cnt    <= 2'd0;
      hdr_di     <= 8'h00;
      hdr_lsb    <= 8'h00;
      hdr_msb    <= 8'h00;
      byte_cnt   <= 16'd0;
      grp_cnt    <= 3'd0;
      // NOTE: the 6-byte group buffer is reset like ordinary flops; it is tiny
      // and keeps X out of quad_pix after a mid-packet reset.
      for (int i = 0; i < 6; i++) grp_buf[i] <= 8'h00;
      crc        <= 16'hFFFF;
      crc_lo     <= 8'h00;
      crc_idx    <= 1'b0;
      fs_pulse   <= 1'b0;
      fe_pulse   <= 1'b0;
      frame_num  <= 16'd0;
      quad_valid <= 1'b0;
      quad_pix   <= 56'd0;
      line_start <= 1'b0;
      line_end   <= 1'b0;
      line_cnt   <= 16'd0;
      err_ecc    <= 1'b0;
      err_vc     <= 1'b0;
      err_dt     <= 1'b0;
      err_wc     <= 1'b0;
      err_len    <= 1'b0;
      err_crc    <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      fs_pulse   <= 1'b0;
      fe_pulse   <= 1'b0;
      quad_valid <= 1'b0;
      line_start <= 1'b0;
      line_end   <= 1'b0;
      err_ecc    <= 1'b0;
      err_vc     <= 1'b0;
      err_dt     <= 1'b0;
      err_wc     <= 1'b0;
      err_len    <= 1'b0;
      err_crc    <= 1'b0;
      err_frame  <= 1'b0;

      if (rx_valid) begin
        unique case (state)
          S_IDLE, S_HDR: begin
            if (hdr_cnt != 2'd3) begin
              unique case (hdr_cnt)
                2'd0:    hdr_di  <= rx_byte;
                2'd1:    hdr_lsb <= rx_byte;
                default: hdr_msb <= rx_byte;
              endcase
              if (rx_eop) begin
                err_len <= 1'b1;
                hdr_cnt <= 2'd0;
                state   <= S_IDLE;
              end else begin
                hdr_cnt <= hdr_cnt + 2'd1;
                state   <= S_HDR;
              end
            end else begin
              hdr_cnt <= 2'd0;
              if (rx_byte != EXP_ECC) begin
                err_ecc <= 1'b1;
                state   <= rx_eop ? S_IDLE : S_DISCARD;
              end else if (hdr_vc != EXP_VC) begin
                err_vc <= 1'b1;
                state  <= rx_eop ? S_IDLE : S_DISCARD;
              end else if (hdr_dt == DT_FS || hdr_dt == DT_FE) begin
                frame_num <= hdr_wc;
                if (hdr_dt == DT_FS) begin
                  fs_pulse <= 1'b1;
                  line_cnt <= 16'd0;
                end else begin
                  fe_pulse <= 1'b1;
                  if (line_cnt != FRAME_LINES) err_frame <= 1'b1;
                end
                state <= rx_eop ? S_IDLE : S_HDR;
              end else if (hdr_dt == DT_RAW14) begin
                if (!wc_ok) begin
                  err_wc <= 1'b1;
                  state  <= rx_eop ? S_IDLE : S_DISCARD;
                end else if (rx_eop) begin
                  // Burst ends before any payload: a truncated packet.
                  err_len <= 1'b1;
                  state   <= S_IDLE;
                end else begin
                  line_start <= 1'b1;
                  byte_cnt   <= hdr_wc;
                  grp_cnt    <= 3'd0;
                  crc        <= 16'hFFFF;
                  state      <= S_PAYLOAD;
                end
              end else begin
                err_dt <= 1'b1;
                state  <= rx_eop ? S_IDLE : S_DISCARD;
              end
            end
          end

          S_PAYLOAD: begin
            crc      <= crc_step(crc, rx_byte);
            byte_cnt <= byte_cnt - 16'd1;
            if (grp_cnt == 3'd6) begin
              quad_pix   <= quad_next;
              quad_valid <= 1'b1;
              grp_cnt    <= 3'd0;
            end else begin
              grp_buf[grp_cnt] <= rx_byte;
              grp_cnt          <= grp_cnt + 3'd1;
            end
            if (rx_eop) begin
              err_len <= 1'b1;
              state   <= S_IDLE;
            end else if (byte_cnt == 16'd1) begin
              crc_idx <= 1'b0;
              state   <= S_CRC;
            end
          end

          S_CRC: begin
            if (!crc_idx) begin
              crc_lo  <= rx_byte;
              crc_idx <= 1'b1;
              if (rx_eop) begin
                err_len <= 1'b1;
                crc_idx <= 1'b0;
                state   <= S_IDLE;
              end
            end else begin
              crc_idx <= 1'b0;
              if ({rx_byte, crc_lo} == crc) begin
                line_end <= 1'b1;
                line_cnt <= line_cnt + 16'd1;
              end else begin
                err_crc <= 1'b1;
              end
              state <= rx_eop ? S_IDLE : S_HDR;
            end
          end

          S_DISCARD: begin
            if (rx_eop) state <= S_IDLE;
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csi_rx_packet_decoder.sv
// Scoreboard bench for csi_rx_packet_decoder: stimulus pushes expected events,
// a negedge monitor pops and compares every output pulse the DUT presents.
module tb_csi_rx_packet_decoder;

  typedef enum logic [3:0] {
    EV_FS, EV_FE, EV_FRAME, EV_LS, EV_QUAD, EV_LE,
    EV_ECC, EV_VC, EV_DT, EV_WC, EV_LEN, EV_CRC
  } ev_kind_t;

  typedef struct {
    ev_kind_t    kind;
    logic [63:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  gap_max = 0;
  int  exp_line_cnt = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_eop = 1'b0;
  logic        fs_pulse, fe_pulse, quad_valid, line_start, line_end;
  logic [15:0] frame_num, line_cnt;
  logic [55:0] quad_pix;
  logic        err_ecc, err_vc, err_dt, err_wc, err_len, err_crc, err_frame;

  always #5 clk = ~clk;

  csi_rx_packet_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .rx_eop    (rx_eop),
    .fs_pulse  (fs_pulse),
    .fe_pulse  (fe_pulse),
    .frame_num (frame_num),
    .quad_valid(quad_valid),
    .quad_pix  (quad_pix),
    .line_start(line_start),
    .line_end  (line_end),
    .line_cnt  (line_cnt),
    .err_ecc   (err_ecc),
    .err_vc    (err_vc),
    .err_dt    (err_dt),
    .err_wc    (err_wc),
    .err_len   (err_len),
    .err_crc   (err_crc),
    .err_frame (err_frame)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input ev_kind_t k, input logic [63:0] d);
    exp_q.push_back('{kind: k, data: d});
  endtask

  task automatic observe(input ev_kind_t kind, input logic [63:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected %s: got data %h, expected no event", kind.name(), data);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("event order (got %s, expected %s)", kind.name(), e.kind.name()),
            64'(kind), 64'(e.kind));
      check({kind.name(), " data"}, data, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (fs_pulse)   observe(EV_FS, 64'(frame_num));
      if (fe_pulse)   observe(EV_FE, 64'(frame_num));
      if (err_frame)  observe(EV_FRAME, 64'd0);
      if (line_start) observe(EV_LS, 64'd0);
      if (quad_valid) observe(EV_QUAD, 64'(quad_pix));
      if (line_end)   observe(EV_LE, 64'(line_cnt));
      if (err_crc)    observe(EV_CRC, 64'(line_cnt));
      if (err_ecc)    observe(EV_ECC, 64'd0);
      if (err_vc)     observe(EV_VC, 64'd0);
      if (err_dt)     observe(EV_DT, 64'd0);
      if (err_wc)     observe(EV_WC, 64'd0);
      if (err_len)    observe(EV_LEN, 64'd0);
    end
  end

  // Reference CRC: bit-serial, reflected polynomial, LSB of each byte first.
  function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r  = {1'b0, r[15:1]};
      if (fb) r = r ^ 16'h8408;
    end
    return r;
  endfunction

  // g holds b0 in [7:0] .. b6 in [55:48]; the low 6 bits of P1..P4 are
  // consecutive 6-bit fields of the 24-bit word {b6,b5,b4}.
  function automatic logic [55:0] ref_unpack(input logic [55:0] g);
    logic [55:0] q;
    logic [23:0] lows;
    lows = g[55:32];
    for (int n = 0; n < 4; n++) q[14*n +: 14] = {g[8*n +: 8], lows[6*n +: 6]};
    return q;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic eop);
    int n;
    rx_byte  = b;
    rx_valid = 1'b1;
    rx_eop   = eop;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_eop   = 1'b0;
    n = (gap_max > 0) ? int'($urandom_range(gap_max, 1)) : 0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_burst(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i], i == bytes.size() - 1);
  endtask

  task automatic send_short(input logic [5:0] dt, input logic [15:0] num, input logic eop);
    send_byte({2'b00, dt}, 1'b0);
    send_byte(num[7:0], 1'b0);
    send_byte(num[15:8], 1'b0);
    if (dt == 6'h00) begin
      push(EV_FS, 64'(num));
      exp_line_cnt = 0;
    end else begin
      push(EV_FE, 64'(num));
      if (exp_line_cnt != 4) push(EV_FRAME, 64'd0);
    end
    send_byte(8'hCC, eop);
  endtask

  // RAW14 line of 28 bytes; trunc_at >= 0 ends the burst on that payload byte.
  task automatic send_line(input int seed, input logic bad_crc, input logic eop, input int trunc_at);
    logic [55:0] g;
    logic [15:0] c;
    logic [7:0]  pb;
    c = 16'hFFFF;
    g = 56'd0;
    send_byte(8'h2D, 1'b0);
    send_byte(8'h1C, 1'b0);
    send_byte(8'h00, 1'b0);
    push(EV_LS, 64'd0);
    send_byte(8'hCC, 1'b0);
    for (int k = 0; k < 28; k++) begin
      pb = 8'(seed * 29 + k * 13 + 7);
      g  = {pb, g[55:8]};
      c  = ref_crc(c, pb);
      if (k % 7 == 6) push(EV_QUAD, 64'(ref_unpack(g)));
      if (k == trunc_at) begin
        push(EV_LEN, 64'd0);
        send_byte(pb, 1'b1);
        return;
      end
      send_byte(pb, 1'b0);
    end
    if (bad_crc) push(EV_CRC, 64'(exp_line_cnt));
    else begin
      exp_line_cnt++;
      push(EV_LE, 64'(exp_line_cnt));
    end
    send_byte(c[7:0] ^ {7'd0, bad_crc}, 1'b0);
    send_byte(c[15:8], eop);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    check({tag, " pending events"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " pulses"},
          64'({fs_pulse, fe_pulse, quad_valid, line_start, line_end,
               err_ecc, err_vc, err_dt, err_wc, err_len, err_crc, err_frame}), 64'd0);
    check({tag, " quad_pix"}, 64'(quad_pix), 64'd0);
    check({tag, " frame_num"}, 64'(frame_num), 64'd0);
    check({tag, " line_cnt"}, 64'(line_cnt), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // FS, four good lines (last one back-to-back with FE), FE with no frame error.
    send_short(6'h00, 16'h0005, 1'b1);
    for (int l = 1; l <= 3; l++) send_line(l, 1'b0, 1'b1, -1);
    send_line(4, 1'b0, 1'b0, -1);
    send_short(6'h01, 16'h0005, 1'b1);
    drain("frame");
    check("line_cnt after frame", 64'(line_cnt), 64'd4);

    // Word-count errors, then a normal FS.
    push(EV_WC, 64'd0);
    send_burst('{8'h2D, 8'h1B, 8'h00, 8'hCC, 8'h11, 8'h22, 8'h33});
    push(EV_WC, 64'd0);
    send_burst('{8'h2D, 8'h0E, 8'h00, 8'hCC, 8'h44});
    push(EV_WC, 64'd0);
    send_burst('{8'h2D, 8'h00, 8'h00, 8'hCC});
    send_short(6'h00, 16'h0006, 1'b1);

    // ECC, VC and DT errors.
    push(EV_ECC, 64'd0);
    send_burst('{8'h00, 8'h07, 8'h00, 8'hCD, 8'hAA, 8'hBB});
    push(EV_VC, 64'd0);
    send_burst('{8'h6D, 8'h1C, 8'h00, 8'hCC, 8'h01, 8'h02, 8'h03});
    push(EV_DT, 64'd0);
    send_burst('{8'h12, 8'h04, 8'h00, 8'hCC, 8'h09});
    drain("header errors");
    check("line_cnt after FS", 64'(line_cnt), 64'd0);

    // Bad CRC leaves line_cnt, a good line advances it, truncated payload.
    send_line(7, 1'b1, 1'b1, -1);
    send_line(8, 1'b0, 1'b1, -1);
    send_line(9, 1'b0, 1'b1, 9);
    send_short(6'h01, 16'h0008, 1'b1);
    drain("crc and length");
    check("line_cnt after crc error", 64'(line_cnt), 64'd1);

    // Random rx_valid gaps of 1-5 cycles.
    gap_max = 5;
    send_short(6'h00, 16'h0020, 1'b1);
    send_line(10, 1'b0, 1'b1, -1);
    send_line(11, 1'b0, 1'b1, -1);
    send_short(6'h01, 16'h0020, 1'b1);
    gap_max = 0;
    drain("gapped");
    check("line_cnt gapped", 64'(line_cnt), 64'd2);

    // eop inside the header.
    push(EV_LEN, 64'd0);
    send_burst('{8'h00, 8'h05});
    drain("header eop");

    // Reset in the middle of a payload.
    send_byte(8'h2D, 1'b0);
    send_byte(8'h1C, 1'b0);
    send_byte(8'h00, 1'b0);
    push(EV_LS, 64'd0);
    send_byte(8'hCC, 1'b0);
    for (int k = 0; k < 5; k++) send_byte(8'(k + 1), 1'b0);
    rx_byte  = 8'h77;
    rx_valid = 1'b1;
    rst_n    = 1'b0;
    #1;
    check_reset_values("mid-packet reset");
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_line_cnt = 0;
    @(posedge clk);
    #1;
    send_short(6'h00, 16'h0009, 1'b1);
    drain("after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
